// File: rtl/vga_fb_reader.sv
// Scan-out reader: 640x480@60 VGA timing over a 2x-doubled framebuffer, with sync/blank
// pipelined to match the read latency. Optional checkerboard output under TEST_PATTERN_EN.
module vga_fb_reader #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_W       = 320,
  parameter int FB_H       = 240,
  parameter int COLOR_W    = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
`ifdef TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic               rd_en,
  output logic [10:0]        x_coord,
  output logic [10:0]        y_coord,
  input  logic [COLOR_W-1:0] rd_data,
  output logic [COLOR_W-1:0] pixel_out,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_n,
  output logic               frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  // Reads never leave the framebuffer, even if the visible area were set larger than 2x it.
  localparam int H_ACT = (H_VISIBLE < 2 * FB_W) ? H_VISIBLE : 2 * FB_W;
  localparam int V_ACT = (V_VISIBLE < 2 * FB_H) ? V_VISIBLE : 2 * FB_H;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACT);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACT);
  localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [10:0] h_cnt, v_cnt;
  logic        active_c;
  logic        hs_a, vs_a, first_a;

  logic [RD_LATENCY-1:0] act_sr, hs_sr, vs_sr, first_sr;
`ifdef TEST_PATTERN_EN
  logic [RD_LATENCY-1:0] chk_sr;
`endif

  assign active_c = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Address stage: each stored pixel covers a 2x2 block of screen pixels.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_en   <= 1'b0;
      x_coord <= '0;
      y_coord <= '0;
      hs_a    <= 1'b1;
      vs_a    <= 1'b1;
      first_a <= 1'b0;
    end else begin
      rd_en   <= active_c;
      x_coord <= active_c ? {1'b0, h_cnt[10:1]} : '0;
      y_coord <= active_c ? {1'b0, v_cnt[10:1]} : '0;
      hs_a    <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
      vs_a    <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
      first_a <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end
  end

  // Delay line matching the framebuffer read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_sr   <= '0;
      hs_sr    <= '1;
      vs_sr    <= '1;
      first_sr <= '0;
    end else begin
      act_sr[0]   <= rd_en;
      hs_sr[0]    <= hs_a;
      vs_sr[0]    <= vs_a;
      first_sr[0] <= first_a;
      for (int i = 1; i < RD_LATENCY; i++) begin
        act_sr[i]   <= act_sr[i-1];
        hs_sr[i]    <= hs_sr[i-1];
        vs_sr[i]    <= vs_sr[i-1];
        first_sr[i] <= first_sr[i-1];
      end
    end
  end

`ifdef TEST_PATTERN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_sr <= '0;
    end else begin
      chk_sr[0] <= x_coord[3] ^ y_coord[3];
      for (int i = 1; i < RD_LATENCY; i++) chk_sr[i] <= chk_sr[i-1];
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_out   <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
`ifdef TEST_PATTERN_EN
      if (!act_sr[RD_LATENCY-1])
        pixel_out <= '0;
      else if (test_mode)
        pixel_out <= {COLOR_W{chk_sr[RD_LATENCY-1]}};
      else
        pixel_out <= rd_data;
`else
      pixel_out   <= act_sr[RD_LATENCY-1] ? rd_data : '0;
`endif
      hsync       <= hs_sr[RD_LATENCY-1];
      vsync       <= vs_sr[RD_LATENCY-1];
      blank_n     <= act_sr[RD_LATENCY-1];
      frame_start <= first_sr[RD_LATENCY-1];
    end
  end

endmodule
